// File: rtl/bf_fetch.sv
// Instruction fetch and bracket-matching loop control for the bfX core.
// Walks the code region two clocks per byte and presents decoded instructions over valid/ready.
module bf_fetch #(
    parameter int unsigned CODE_BASE  = 0,
    parameter int unsigned CODE_DEPTH = 256,
    parameter int unsigned DEPTH_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        instr_valid,
    output logic [7:0]  instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    input  logic        jump_req,
    output logic        halt,
    output logic        error
);

    // state     | meaning
    // S_LOAD    | pc on mem_addr, memory capturing byte
    // S_DECODE  | classify mem_data: instruction / comment / end
    // S_PRESENT | instr_valid=1, waiting for instr_ready
    // S_SF_LOAD | forward scan, pc on mem_addr
    // S_SF_SMP  | forward scan, classify byte and track depth
    // S_SB_LOAD | backward scan, pc on mem_addr
    // S_SB_SMP  | backward scan, classify byte and track depth
    // S_HALT    | end of program, sticky until rst
    // S_ERROR   | unmatched bracket or depth overflow, sticky until rst
    typedef enum logic [3:0] {
        S_LOAD, S_DECODE, S_PRESENT, S_SF_LOAD, S_SF_SMP,
        S_SB_LOAD, S_SB_SMP, S_HALT, S_ERROR
    } state_t;

    localparam logic [15:0]        PC_BASE   = 16'(CODE_BASE);
    localparam logic [15:0]        PC_END    = 16'(CODE_BASE + CODE_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [7:0]         CH_OPEN   = 8'h5B;
    localparam logic [7:0]         CH_CLOSE  = 8'h5D;

    state_t             state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic [15:0]        ipc_q, ipc_d;
    logic [7:0]         instr_q, instr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               step_back;

    function automatic logic is_instr(input logic [7:0] b);
        case (b)
            8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_instr = 1'b1;
            default: is_instr = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            pc_q    <= PC_BASE;
            ipc_q   <= PC_BASE;
            instr_q <= 8'h00;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            depth_q <= depth_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ipc_d     = ipc_q;
        instr_d   = instr_q;
        depth_d   = depth_q;
        step_back = 1'b0;

        case (state_q)
            S_LOAD: begin
                state_d = (pc_q == PC_END) ? S_HALT : S_DECODE;
            end
            S_DECODE: begin
                if (mem_data == 8'h00) begin
                    state_d = S_HALT;
                end else if (is_instr(mem_data)) begin
                    instr_d = mem_data;
                    ipc_d   = pc_q;
                    state_d = S_PRESENT;
                end else begin
                    pc_d    = pc_q + 16'd1;
                    state_d = S_LOAD;
                end
            end
            S_PRESENT: begin
                if (instr_ready) begin
                    if (jump_req && instr_q == CH_OPEN) begin
                        depth_d = DEPTH_ONE;
                        pc_d    = pc_q + 16'd1;
                        state_d = S_SF_LOAD;
                    end else if (jump_req && instr_q == CH_CLOSE) begin
                        if (pc_q == PC_BASE) begin
                            state_d = S_ERROR;
                        end else begin
                            depth_d = DEPTH_ONE;
                            pc_d    = pc_q - 16'd1;
                            state_d = S_SB_LOAD;
                        end
                    end else begin
                        pc_d    = pc_q + 16'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_SF_LOAD: begin
                state_d = (pc_q == PC_END) ? S_ERROR : S_SF_SMP;
            end
            S_SF_SMP: begin
                pc_d    = pc_q + 16'd1;
                state_d = S_SF_LOAD;
                if (mem_data == 8'h00) begin
                    pc_d    = pc_q;
                    state_d = S_ERROR;
                end else if (mem_data == CH_OPEN) begin
                    if (depth_q == DEPTH_MAX) begin
                        pc_d    = pc_q;
                        state_d = S_ERROR;
                    end else begin
                        depth_d = depth_q + DEPTH_ONE;
                    end
                end else if (mem_data == CH_CLOSE) begin
                    depth_d = depth_q - DEPTH_ONE;
                    if (depth_q == DEPTH_ONE) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_SB_LOAD: begin
                state_d = S_SB_SMP;
            end
            S_SB_SMP: begin
                step_back = 1'b1;
                if (mem_data == CH_CLOSE) begin
                    if (depth_q == DEPTH_MAX) begin
                        step_back = 1'b0;
                        state_d   = S_ERROR;
                    end else begin
                        depth_d = depth_q + DEPTH_ONE;
                    end
                end else if (mem_data == CH_OPEN) begin
                    depth_d = depth_q - DEPTH_ONE;
                    if (depth_q == DEPTH_ONE) begin
                        step_back = 1'b0;
                        pc_d      = pc_q + 16'd1;
                        state_d   = S_LOAD;
                    end
                end
                // Underflow is checked before the decrement so the pc never wraps.
                if (step_back) begin
                    if (pc_q == PC_BASE) begin
                        state_d = S_ERROR;
                    end else begin
                        pc_d    = pc_q - 16'd1;
                        state_d = S_SB_LOAD;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = (state_q == S_PRESENT);
    assign halt        = (state_q == S_HALT);
    assign error       = (state_q == S_ERROR);

endmodule

// File: tb/tb_bf_fetch.sv
// Self-checking bench for bf_fetch: a program-walking timing model checked every cycle,
// directed programs with literal expectations, and randomized programs/handshakes.
module tb_bf_fetch;

    localparam int BASE   = 0;
    localparam int END_PC = 256;
    localparam int DMAX   = 255;
    localparam int K_INSTR = 0;
    localparam int K_HALT  = 1;
    localparam int K_ERR   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ma1, ma2, ipc1, ipc2;
    logic [7:0]  md1, md2, ins1, ins2;
    logic        val1, val2, halt1, halt2, err1, err2;
    logic        ready, jump;
    logic [7:0]  code [256];

    always #5 clk = ~clk;

    bf_fetch u_dut (
        .clk(clk), .rst(rst), .mem_addr(ma1), .mem_data(md1),
        .instr_valid(val1), .instr(ins1), .instr_pc(ipc1),
        .instr_ready(ready), .jump_req(jump), .halt(halt1), .error(err1)
    );

    bf_fetch #(.DEPTH_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .mem_addr(ma2), .mem_data(md2),
        .instr_valid(val2), .instr(ins2), .instr_pc(ipc2),
        .instr_ready(ready), .jump_req(jump), .halt(halt2), .error(err2)
    );

    always @(posedge clk) begin
        md1 <= (ma1 < 16'd256) ? code[ma1[7:0]] : 8'h00;
        md2 <= (ma2 < 16'd256) ? code[ma2[7:0]] : 8'h00;
    end

    typedef struct { int kind; int b; int pc; int off; } ev_t;
    typedef struct { int b; int pc; int pcyc; int acyc; } log_t;

    log_t lg[$];
    int checks = 0;
    int errors = 0;
    int rdy_mode, jmp_mode;
    int term_kind, term_pc, term_cyc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_ins(input int b);
        return b == 'h2B || b == 'h2D || b == 'h3C || b == 'h3E ||
               b == 'h2E || b == 'h2C || b == 'h5B || b == 'h5D;
    endfunction

    function automatic ev_t mk(input int k, input int b, input int p, input int o);
        ev_t e;
        e.kind = k; e.b = b; e.pc = p; e.off = o;
        return e;
    endfunction

    // Offsets count clocks from the LOAD cycle of pc p (offset 0) to the cycle the event is visible.
    function automatic ev_t walk(input int p, input int off);
        int b;
        for (int n = 0; n < 300; n++) begin
            if (p == END_PC) return mk(K_HALT, 0, p, off + 1);
            b = int'(code[p]);
            if (b == 0) return mk(K_HALT, 0, p, off + 2);
            if (is_ins(b)) return mk(K_INSTR, b, p, off + 2);
            p++;
            off += 2;
        end
        return mk(K_ERR, 0, p, off);
    endfunction

    // Next event after the instruction b at pc p is accepted with jump request j.
    function automatic ev_t xfer(input int b, input int p, input bit j);
        int d, q, off, c;
        if (j && b == 'h5B) begin
            d = 1; q = p + 1; off = 0;
            for (int n = 0; n < 300; n++) begin
                if (q == END_PC) return mk(K_ERR, 0, q, off + 1);
                c = int'(code[q]);
                if (c == 0) return mk(K_ERR, 0, q, off + 2);
                if (c == 'h5B) begin
                    if (d == DMAX) return mk(K_ERR, 0, q, off + 2);
                    d++;
                end else if (c == 'h5D) begin
                    d--;
                    if (d == 0) return walk(q + 1, off + 2);
                end
                q++;
                off += 2;
            end
            return mk(K_ERR, 0, q, off);
        end
        if (j && b == 'h5D) begin
            if (p == BASE) return mk(K_ERR, 0, p, 0);
            d = 1; q = p - 1; off = 0;
            for (int n = 0; n < 300; n++) begin
                c = int'(code[q]);
                if (c == 'h5D) begin
                    if (d == DMAX) return mk(K_ERR, 0, q, off + 2);
                    d++;
                end else if (c == 'h5B) begin
                    d--;
                    if (d == 0) return walk(q + 1, off + 2);
                end
                if (q == BASE) return mk(K_ERR, 0, q, off + 2);
                q--;
                off += 2;
            end
            return mk(K_ERR, 0, q, off);
        end
        return walk(p + 1, 0);
    endfunction

    task automatic set_code(input string s, input logic [7:0] fill);
        for (int i = 0; i < 256; i++) code[i] = fill;
        for (int i = 0; i < s.len(); i++) code[i] = s[i];
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, int'(val1), 0);
        chk({tag, "_instr"}, int'(ins1), 0);
        chk({tag, "_ipc"},   int'(ipc1), BASE);
        chk({tag, "_addr"},  int'(ma1),  BASE);
        chk({tag, "_halt"},  int'(halt1), 0);
        chk({tag, "_error"}, int'(err1),  0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; ready = 1'b0; jump = 1'b0;
        #1 check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs the loaded program; the single per-cycle compare against the model lives here.
    task automatic run_prog(input int max_cyc, input int stop_at);
        ev_t ev;
        int cnt, cyc, tail, hold, pstart;
        bit r, j, jumped;
        log_t e;
        lg.delete();
        term_kind = -1; term_pc = -1; term_cyc = -1;
        reset_dut();
        ev = walk(BASE, 0);
        cnt = ev.off; cyc = 0; tail = 0; hold = 0; pstart = -1; jumped = 0;
        while (cyc < max_cyc && tail < 3 && cyc != stop_at) begin
            @(negedge clk);
            if (cnt > 0) begin
                chk("idle_flags", int'({val1, halt1, err1}), 0);
                cnt--;
                ready = 1'($urandom % 2); jump = 1'($urandom % 2);
            end else if (ev.kind == K_INSTR) begin
                chk("pres_flags", int'({val1, halt1, err1}), 4);
                chk("pres_instr", int'(ins1), ev.b);
                chk("pres_ipc",   int'(ipc1), ev.pc);
                chk("pres_addr",  int'(ma1),  ev.pc);
                if (pstart < 0) pstart = cyc;
                case (rdy_mode)
                    0: r = 1'b1;
                    1: r = ($urandom % 3) != 0;
                    default: begin
                        r = 1'b1;
                        if (ev.b == 'h3E && hold < 5) begin r = 1'b0; hold++; end
                    end
                endcase
                case (jmp_mode)
                    0: j = 1'b0;
                    1: j = 1'b1;
                    2: j = (ev.b == 'h5D) ? (($urandom % 4) == 0) : 1'($urandom % 2);
                    default: j = (ev.b == 'h5D) && !jumped;
                endcase
                ready = r; jump = j;
                if (r) begin
                    e.b = ev.b; e.pc = ev.pc; e.pcyc = pstart; e.acyc = cyc;
                    lg.push_back(e);
                    if (j && ev.b == 'h5D) jumped = 1'b1;
                    ev = xfer(ev.b, ev.pc, j);
                    cnt = ev.off;
                    pstart = -1;
                end
            end else begin
                chk("term_flags", int'({val1, halt1, err1}), (ev.kind == K_HALT) ? 2 : 1);
                chk("term_addr",  int'(ma1), ev.pc);
                if (tail == 0) begin
                    term_kind = ev.kind; term_pc = ev.pc; term_cyc = cyc;
                end
                tail++;
                ready = 1'($urandom % 2); jump = 1'($urandom % 2);
            end
            cyc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        int len, k;
        ready = 1'b0; jump = 1'b0;

        // straight-line program
        rdy_mode = 0; jmp_mode = 0;
        set_code("+-><", 8'h00);
        run_prog(100, -1);
        chk("t1_count", lg.size(), 4);
        if (lg.size() == 4) begin
            chk("t1_b0", lg[0].b, 'h2B); chk("t1_b1", lg[1].b, 'h2D);
            chk("t1_b2", lg[2].b, 'h3E); chk("t1_b3", lg[3].b, 'h3C);
            chk("t1_first_cyc", lg[0].pcyc, 2);
            for (int i = 1; i < 4; i++) begin
                chk("t1_pc", lg[i].pc, i);
                chk("t1_spacing", lg[i].pcyc - lg[i-1].pcyc, 3);
            end
        end
        chk("t1_term", term_kind, K_HALT); chk("t1_term_pc", term_pc, 4);
        chk("t1_term_cyc", term_cyc, 14);

        // comments skipped
        set_code("a+b", 8'h00);
        run_prog(100, -1);
        chk("t2_count", lg.size(), 1);
        if (lg.size() == 1) begin
            chk("t2_b", lg[0].b, 'h2B); chk("t2_pc", lg[0].pc, 1);
            chk("t2_cyc", lg[0].pcyc, 4);
        end
        chk("t2_term", term_kind, K_HALT);

        // end of region without terminator
        set_code("", 8'h61);
        run_prog(700, -1);
        chk("t2b_count", lg.size(), 0);
        chk("t2b_term", term_kind, K_HALT); chk("t2b_term_pc", term_pc, 256);
        chk("t2b_term_cyc", term_cyc, 513);

        // backpressure on '>'
        rdy_mode = 2;
        set_code(">+", 8'h00);
        run_prog(100, -1);
        chk("t3_count", lg.size(), 2);
        if (lg.size() == 2) begin
            chk("t3_hold", lg[0].acyc - lg[0].pcyc, 5);
            chk("t3_next", lg[1].pcyc - lg[0].acyc, 3);
        end
        rdy_mode = 0;

        // forward scan
        jmp_mode = 1;
        set_code("[+[-]].", 8'h00);
        run_prog(200, -1);
        chk("t4_count", lg.size(), 2);
        if (lg.size() == 2) begin
            chk("t4_b", lg[1].b, 'h2E); chk("t4_pc", lg[1].pc, 6);
            chk("t4_gap", lg[1].pcyc - lg[0].acyc, 13);
        end

        // backward scan, then the same program without the jump
        jmp_mode = 3;
        set_code("+[-]", 8'h00);
        run_prog(200, -1);
        chk("t5_count", lg.size(), 6);
        if (lg.size() == 6) begin
            chk("t5_b", lg[4].b, 'h2D); chk("t5_pc", lg[4].pc, 2);
            chk("t5_gap", lg[4].pcyc - lg[3].acyc, 7);
        end
        chk("t5_term_pc", term_pc, 4);
        jmp_mode = 0;
        run_prog(200, -1);
        chk("t5b_count", lg.size(), 4);
        chk("t5b_term", term_kind, K_HALT); chk("t5b_term_pc", term_pc, 4);

        // errors
        jmp_mode = 1;
        set_code("[+", 8'h00);
        run_prog(100, -1);
        chk("t6a_term", term_kind, K_ERR); chk("t6a_pc", term_pc, 2);
        set_code("]", 8'h00);
        run_prog(100, -1);
        chk("t6b_term", term_kind, K_ERR); chk("t6b_pc", term_pc, 0);
        chk("t6b_cyc", term_cyc, 3);
        set_code("[[[[", 8'h00);
        run_prog(100, -1);
        chk("t6c_main_term", term_kind, K_ERR); chk("t6c_main_pc", term_pc, 4);
        chk("t6c_ovf_error", int'(err2), 1);
        chk("t6c_ovf_pc", int'(ma2), 3);
        chk("t6c_ovf_halt", int'(halt2), 0);

        // reset during a forward scan
        set_code("[", 8'h61);
        code[255] = 8'h5D;
        run_prog(100, 9);
        @(negedge clk);
        chk("t6d_midscan_addr", int'(ma1), 4);
        chk("t6d_midscan_instr", int'(ins1), 'h5B);
        rst = 1'b1;
        #1 check_reset_vals("t6d");

        // randomized programs and handshakes
        rdy_mode = 1; jmp_mode = 2;
        for (int t = 0; t < 40; t++) begin
            len = 1 + int'($urandom % 60);
            for (int i = 0; i < 256; i++) code[i] = 8'h00;
            for (int i = 0; i < len; i++) begin
                k = int'($urandom % 10);
                case (k)
                    0: code[i] = 8'h2B; 1: code[i] = 8'h2D; 2: code[i] = 8'h3C;
                    3: code[i] = 8'h3E; 4: code[i] = 8'h2E; 5: code[i] = 8'h2C;
                    6: code[i] = 8'h5B; 7: code[i] = 8'h5D;
                    default: code[i] = 8'(8'h61 + ($urandom % 20));
                endcase
            end
            if ($urandom % 8 == 0)
                for (int i = len; i < 256; i++) code[i] = 8'h7A;
            run_prog(1500, -1);
        end

        s = "";
        $display("Simulation finished: %0d checks, %0d errors%s", checks, errors, s);
        $finish;
    end

endmodule
